// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring divider, signed/unsigned, quotient or remainder
module divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] c,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic             is_zero,
    output logic             is_negative
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;       // raw captured dividend, kept for the divide-by-zero remainder
    logic [WIDTH-1:0] b_q, b_d;       // captured divisor, then its magnitude
    logic [WIDTH-1:0] quo_q, quo_d;   // dividend magnitude shifting out, quotient bits shifting in
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             sgn_q, sgn_d;
    logic             rsel_q, rsel_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             zdiv_q, zdiv_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

    // One restoring step: shift in the next dividend bit and trial-subtract with a WIDTH+1-bit subtractor
    always_comb begin
        shifted = {rem_q, quo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = (shifted >= {1'b0, b_q});
        q_fix   = zdiv_q ? {WIDTH{1'b1}} : (qneg_q ? -quo_q : quo_q);
        r_fix   = zdiv_q ? a_q : (rneg_q ? -rem_q : rem_q);
    end

    // Next-state and datapath updates for the IDLE/PREP/RUN/FIX/DONE sequence
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        rsel_d  = rsel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        zdiv_d  = zdiv_q;
        c_d     = c_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sgn_d   = op[1];
                    rsel_d  = op[0];
                    busy_d  = 1'b1;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                qneg_d  = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                rneg_d  = sgn_q & a_q[WIDTH-1];
                quo_d   = (sgn_q && a_q[WIDTH-1]) ? -a_q : a_q;
                b_d     = (sgn_q && b_q[WIDTH-1]) ? -b_q : b_q;
                zdiv_d  = (b_q == '0);
                rem_d   = '0;
                cnt_d   = CW'(WIDTH);
                state_d = S_RUN;
            end
            S_RUN: begin
                rem_d = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], ge};
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                c_d     = rsel_q ? r_fix : q_fix;
                dz_d    = zdiv_q;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with synchronous active-low clear of everything
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            rsel_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            zdiv_q  <= 1'b0;
            c_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            rsel_q  <= rsel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            zdiv_q  <= zdiv_d;
            c_q     <= c_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign c           = c_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign div_zero    = dz_q;
    assign is_zero     = (c_q == '0);
    assign is_negative = c_q[WIDTH-1];

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - self-checking bench for divider: vector table, random model, protocol sequences
module tb_divider;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] c;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic        is_zero;
    logic        is_negative;

    int checks = 0;
    int errors = 0;

    divider #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .a          (a),
        .b          (b),
        .op         (op),
        .c          (c),
        .busy       (busy),
        .done       (done),
        .div_zero   (div_zero),
        .is_zero    (is_zero),
        .is_negative(is_negative)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] va;
        logic [31:0] vb;
        logic [1:0]  vop;
        logic [31:0] vc;
        logic        vdz;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: plain integer division, truncating toward zero, with the zero-divisor rule
    function automatic logic [32:0] model(input logic [31:0] ma, input logic [31:0] mb, input logic [1:0] mop);
        longint sa, sb, q, r;
        logic [31:0] res;
        if (mb == 32'd0) begin
            res = mop[0] ? ma : 32'hFFFF_FFFF;
            return {1'b1, res};
        end
        if (mop[1]) begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
        end else begin
            sa = longint'({32'd0, ma});
            sb = longint'({32'd0, mb});
        end
        q = sa / sb;
        r = sa % sb;
        res = mop[0] ? r[31:0] : q[31:0];
        return {1'b0, res};
    endfunction

    // Issue one start, scramble inputs afterwards, and count edges until done
    task automatic do_div(input logic [31:0] ta, input logic [31:0] tb, input logic [1:0] top,
                          output int lat);
        @(negedge clk);
        a = ta; b = tb; op = top; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_check(input string name, input logic [31:0] ta, input logic [31:0] tb,
                             input logic [1:0] top, input logic [32:0] exp);
        int lat;
        logic [31:0] held;
        do_div(ta, tb, top, lat);
        chk({name, " latency"}, 64'(lat), 64'd34);
        chk({name, " c"}, {32'd0, c}, {32'd0, exp[31:0]});
        chk({name, " div_zero"}, {63'd0, div_zero}, {63'd0, exp[32]});
        chk({name, " is_zero"}, {63'd0, is_zero}, {63'd0, exp[31:0] == 32'd0});
        chk({name, " is_negative"}, {63'd0, is_negative}, {63'd0, exp[31]});
        held = c;
        @(posedge clk); #1;
        chk({name, " done pulse width"}, {63'd0, done}, 64'd0);
        chk({name, " c held"}, {32'd0, c}, {32'd0, held});
    endtask

    vec_t vecs[$];

    initial begin
        int lat;
        int ndone;
        logic [31:0] ra, rb;
        logic [1:0]  rop;

        resetn = 1'b0; start = 1'b0; a = '0; b = '0; op = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset c", {32'd0, c}, 64'd0);
        chk("reset busy", {63'd0, busy}, 64'd0);
        chk("reset done", {63'd0, done}, 64'd0);
        chk("reset div_zero", {63'd0, div_zero}, 64'd0);
        chk("reset is_zero", {63'd0, is_zero}, 64'd1);
        @(negedge clk); resetn = 1'b1;

        vecs.push_back('{32'd100, 32'd7, 2'b00, 32'd14, 1'b0});
        vecs.push_back('{32'd100, 32'd7, 2'b01, 32'd2, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 2'b10, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{32'hFFFF_FFF9, 32'd2, 2'b11, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'h1234_5678, 32'd0, 2'b00, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'h1234_5678, 32'd0, 2'b01, 32'h1234_5678, 1'b1});
        vecs.push_back('{32'hFFFF_FFF9, 32'd0, 2'b10, 32'hFFFF_FFFF, 1'b1});
        vecs.push_back('{32'hFFFF_FFF9, 32'd0, 2'b11, 32'hFFFF_FFF9, 1'b1});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 1'b0});
        vecs.push_back('{32'h8000_0000, 32'hFFFF_FFFF, 2'b11, 32'd0, 1'b0});
        vecs.push_back('{32'd7, 32'hFFFF_FFFE, 2'b10, 32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{32'd7, 32'hFFFF_FFFE, 2'b11, 32'd1, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'd1, 2'b00, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{32'd5, 32'd9, 2'b00, 32'd0, 1'b0});
        vecs.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b01, 32'd0, 1'b0});

        foreach (vecs[i]) begin
            run_check($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vop,
                      {vecs[i].vdz, vecs[i].vc});
        end

        for (int i = 0; i < 40; i++) begin
            ra  = $urandom;
            rb  = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom >> $urandom_range(0, 31);
            if (rb[0] && i[1]) rb = -rb;
            rop = 2'($urandom);
            run_check($sformatf("rnd%0d", i), ra, rb, rop, model(ra, rb, rop));
        end

        // Start while busy is ignored: one done carrying the first result
        @(negedge clk);
        a = 32'd1000; b = 32'd10; op = 2'b00; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        ndone = 0; lat = -1;
        for (int n = 1; n <= 45; n++) begin
            if (n == 10) begin
                @(negedge clk); a = 32'd50; b = 32'd5; op = 2'b01; start = 1'b1;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (n == 12) chk("busy mid-run", {63'd0, busy}, 64'd1);
            if (done) begin
                ndone++;
                if (lat < 0) begin
                    lat = n;
                    chk("busy-start c", {32'd0, c}, 64'd100);
                    chk("busy at done", {63'd0, busy}, 64'd0);
                end
            end
        end
        chk("busy-start latency", 64'(lat), 64'd34);
        chk("busy-start done count", 64'(ndone), 64'd1);

        // Back-to-back: start held from the done cycle is ignored in DONE, taken in IDLE
        do_div(32'd81, 32'd9, 2'b00, lat);
        chk("b2b first c", {32'd0, c}, 64'd9);
        a = 32'd64; b = 32'd8; op = 2'b00; start = 1'b1;
        lat = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); #1;
            if (n == 2) start = 1'b0;
            if (done) begin
                lat = n;
                break;
            end
        end
        chk("b2b latency", 64'(lat), 64'd36);
        chk("b2b c", {32'd0, c}, 64'd8);

        // Reset mid-operation aborts cleanly
        @(negedge clk);
        a = 32'd77; b = 32'd3; op = 2'b00; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk); resetn = 1'b0;
        @(posedge clk); #1;
        chk("mid-reset busy", {63'd0, busy}, 64'd0);
        chk("mid-reset c", {32'd0, c}, 64'd0);
        @(negedge clk); resetn = 1'b1;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        chk("mid-reset no done", 64'(ndone), 64'd0);
        run_check("post-reset 9/3", 32'd9, 32'd3, 2'b00, {1'b0, 32'd3});

        // Start coincident with reset is discarded
        @(negedge clk); resetn = 1'b0; a = 32'd10; b = 32'd2; op = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); resetn = 1'b1; start = 1'b0;
        ndone = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk); #1;
            if (done || busy) ndone++;
        end
        chk("reset-start discarded", 64'(ndone), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
